// File: rtl/uart_wb_pkg.sv
// Shared types for the UART Wishbone command master: command word and FSM states.
package uart_wb_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] dat;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

endpackage

// File: rtl/uart_cmd_fifo.sv
// Synchronous command FIFO: registered pointers and occupancy, head entry visible combinationally.
module uart_cmd_fifo
    import uart_wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  cmd_t        wdata,
    output cmd_t        rdata,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_wb_cmd_master.sv
// Executes queued UART register commands as single Wishbone classic cycles with timeout,
// returns one response per command, and synchronises the UART interrupt.
module uart_wb_cmd_master
    import uart_wb_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter int         TIMEOUT    = 16,
    parameter logic [3:0] SEL_VAL    = 4'b0001
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_adr_i,
    input  logic [DATA_W-1:0] cmd_dat_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_dat_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    output logic [3:0]        wb_sel_o,
    input  logic              wb_ack_i,
    input  logic              int_i,
    output logic              irq_o,
    output logic              irq_rise_o
);

    localparam int CW  = $clog2(TIMEOUT + 1);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic              bus_q, bus_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic              we_q, we_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rdy_en_q;
    logic [1:0]        sync_q, sync_d;
    logic              rise_q, rise_d;

    cmd_t           fifo_wdata, fifo_head;
    logic           fifo_full, fifo_empty, pop;
    logic [FCW-1:0] fifo_cnt;
    logic           unused_cnt;

    assign unused_cnt = ^fifo_cnt;
    assign fifo_wdata = '{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i};
    // rdy_en_q keeps ready low through reset and the first edge after release.
    assign cmd_ready_o = rdy_en_q && !fifo_full;

    uart_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_i),
        .push  (cmd_valid_i && cmd_ready_o),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_comb begin
        state_d     = state_q;
        bus_d       = bus_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        pop         = 1'b0;
        sync_d      = {sync_q[0], int_i};
        rise_d      = sync_q[0] && !sync_q[1];
        case (state_q)
            IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                adr_d   = fifo_head.adr;
                we_d    = fifo_head.we;
                wdat_d  = fifo_head.we ? fifo_head.dat : '0;
                bus_d   = 1'b1;
                cnt_d   = '0;
                state_d = BUS;
            end
            BUS: begin
                // ACK is tested first so it wins over a coincident timeout.
                if (wb_ack_i) begin
                    bus_d       = 1'b0;
                    rsp_dat_d   = we_q ? '0 : wb_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    bus_d       = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: if (rsp_ready_i) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q     <= IDLE;
            bus_q       <= 1'b0;
            adr_q       <= '0;
            wdat_q      <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rdy_en_q    <= 1'b0;
            sync_q      <= '0;
            rise_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rdy_en_q    <= 1'b1;
            sync_q      <= sync_d;
            rise_q      <= rise_d;
        end
    end

    assign wb_cyc_o    = bus_q;
    assign wb_stb_o    = bus_q;
    assign wb_sel_o    = bus_q ? SEL_VAL : 4'b0000;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = wdat_q;
    assign wb_we_o     = we_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign irq_o       = sync_q[1];
    assign irq_rise_o  = rise_q;

endmodule

// File: tb/tb_uart_wb_cmd_master.sv
// Directed bench for uart_wb_cmd_master: Wishbone slave and response sink driven step by step.
module tb_uart_wb_cmd_master;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i, cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [2:0] cmd_adr_i, wb_adr_o;
    logic [7:0] cmd_dat_i, rsp_dat_o, wb_dat_o, wb_dat_i;
    logic       rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic       wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
    logic [3:0] wb_sel_o;
    logic       int_i, irq_o, irq_rise_o;

    int errs   = 0;
    int checks = 0;
    int n;

    always #5 wb_clk_i = ~wb_clk_i;

    uart_wb_cmd_master dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_we_o     (wb_we_o),
        .wb_stb_o    (wb_stb_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_sel_o    (wb_sel_o),
        .wb_ack_i    (wb_ack_i),
        .int_i       (int_i),
        .irq_o       (irq_o),
        .irq_rise_o  (irq_rise_o)
    );

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [2:0] adr, input logic [7:0] dat);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic consume();
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    task automatic wait_cyc(input string tag);
        for (int i = 0; i < 40 && !wb_cyc_o; i++) tick();
        chk(tag, wb_cyc_o, 1);
    endtask

    initial begin
        wb_rst_i = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_dat_i = '0;
        rsp_ready_i = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0; int_i = 1'b0;
        #2;
        chk("rst_ready", cmd_ready_o, 0);
        chk("rst_outs", {wb_cyc_o, wb_stb_o, rsp_valid_o, irq_o, irq_rise_o, wb_sel_o}, 0);
        tick(); tick();
        chk("rst_hold_ready", cmd_ready_o, 0);
        wb_rst_i = 1'b1;
        tick();
        chk("ready_after_rst", cmd_ready_o, 1);

        // Write adr=3, ACK on the second STB cycle
        push(1'b1, 3'd3, 8'h83);
        chk("t1_no_bypass", wb_cyc_o, 0);
        tick();
        chk("t1_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o},
            {1'b1, 1'b1, 1'b1, 4'b0001, 3'd3, 8'h83});
        tick();
        chk("t1_wait", wb_stb_o, 1);
        wb_ack_i = 1'b1; tick(); wb_ack_i = 1'b0;
        chk("t1_rsp", {wb_cyc_o, wb_sel_o, rsp_valid_o, rsp_err_o, rsp_dat_o},
            {1'b0, 4'b0000, 1'b1, 1'b0, 8'h00});
        consume();
        chk("t1_rsp_drop", rsp_valid_o, 0);

        // Read adr=5, data 0x60 on the second STB cycle
        push(1'b0, 3'd5, 8'hAA);
        tick();
        chk("t2_bus", {wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o}, {1'b1, 1'b0, 3'd5, 8'h00});
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 8'h60; tick(); wb_ack_i = 1'b0; wb_dat_i = '0;
        chk("t2_rsp", {rsp_valid_o, rsp_err_o, rsp_dat_o}, {1'b1, 1'b0, 8'h60});
        consume();

        // Latency: zero-wait ACK, sink always ready
        push(1'b0, 3'd4, 8'h00);
        chk("lat_n1", wb_cyc_o, 0);
        tick();
        chk("lat_n2", wb_cyc_o, 1);
        wb_ack_i = 1'b1; wb_dat_i = 8'h3C; rsp_ready_i = 1'b1;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        chk("lat_n3", {wb_cyc_o, rsp_valid_o, rsp_dat_o}, {1'b0, 1'b1, 8'h3C});
        tick();
        rsp_ready_i = 1'b0;
        chk("lat_n4", {wb_cyc_o, rsp_valid_o}, 0);

        // Read never ACKed: 16 STB cycles then an error response with zero data
        wb_dat_i = 8'hFF;
        push(1'b0, 3'd2, 8'h00);
        tick();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!wb_stb_o) break;
            n++;
            tick();
        end
        chk("t3_stb_len", n, 16);
        chk("t3_rsp", {wb_cyc_o, rsp_valid_o, rsp_err_o, rsp_dat_o}, {1'b0, 1'b1, 1'b1, 8'h00});
        wb_dat_i = '0;

        // Response held for 10 cycles with a command queued behind it
        push(1'b1, 3'd1, 8'h55);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_hold", {wb_cyc_o, rsp_valid_o, rsp_err_o, rsp_dat_o},
                {1'b0, 1'b1, 1'b1, 8'h00});
        end
        consume();
        chk("t5_rel", {wb_cyc_o, rsp_valid_o}, 0);
        tick();
        chk("t5_next", {wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o}, {1'b1, 1'b1, 3'd1, 8'h55});
        wb_ack_i = 1'b1; tick(); wb_ack_i = 1'b0;
        chk("t5_rsp", {rsp_valid_o, rsp_err_o, rsp_dat_o}, {1'b1, 1'b0, 8'h00});
        consume();

        // ACK on the edge that would time out wins
        push(1'b0, 3'd6, 8'h00);
        tick();
        repeat (15) tick();
        chk("to_edge_stb", wb_stb_o, 1);
        wb_ack_i = 1'b1; wb_dat_i = 8'h5A; tick(); wb_ack_i = 1'b0; wb_dat_i = '0;
        chk("to_ack_wins", {rsp_valid_o, rsp_err_o, rsp_dat_o}, {1'b1, 1'b0, 8'h5A});
        consume();

        // Five reads with ACK stalled: FIFO fills, then all drain in order
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_adr_i = 3'(i);
            chk("t4_ready", cmd_ready_o, 1);
            tick();
        end
        chk("t4_full", cmd_ready_o, 0);
        cmd_adr_i = 3'd7;
        tick(); tick();
        chk("t4_still_full", cmd_ready_o, 0);
        cmd_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_cyc("t4_cyc");
            chk("t4_order", wb_adr_o, k);
            wb_ack_i = 1'b1; wb_dat_i = 8'(16 + k);
            tick();
            wb_ack_i = 1'b0; wb_dat_i = '0;
            chk("t4_rsp", {rsp_valid_o, rsp_err_o, rsp_dat_o}, {1'b1, 1'b0, 8'(16 + k)});
            consume();
        end
        repeat (3) tick();
        chk("t4_drain", {wb_cyc_o, rsp_valid_o, cmd_ready_o}, {1'b0, 1'b0, 1'b1});

        // Reset asserted mid-bus-cycle
        push(1'b0, 3'd0, 8'h00);
        tick();
        chk("t6_bus", wb_cyc_o, 1);
        wb_rst_i = 1'b0;
        #1;
        chk("t6_async", {wb_cyc_o, wb_stb_o, rsp_valid_o, cmd_ready_o}, 0);
        tick();
        wb_rst_i = 1'b1;
        tick();
        chk("t6_ready", cmd_ready_o, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_stale", {wb_cyc_o, rsp_valid_o}, 0);
        end

        // Interrupt synchroniser and edge pulse
        int_i = 1'b1;
        tick();
        chk("irq_e1", {irq_o, irq_rise_o}, 2'b00);
        tick();
        chk("irq_e2", {irq_o, irq_rise_o}, 2'b11);
        tick();
        chk("irq_e3", {irq_o, irq_rise_o}, 2'b10);
        int_i = 1'b0;
        tick(); tick();
        chk("irq_low", {irq_o, irq_rise_o}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
